// File: rtl/victim_cache.sv
// Fully-associative victim cache holding clean lines evicted from the dcache.
// Lookup is zero-latency (victim_hit_o / hit_line_o are combinational); all
// other state updates on the rising edge of clk with synchronous active-low
// reset rst_n.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   lookup_req_i          LSU lookup valid
//   lookup_addr_i         line address being looked up
//   victim_hit_o          lookup hit (combinational)
//   hit_line_o            data of hit entry, zero on miss (combinational)
//   write_to_victim_i     insert evicted line (evict_addr_i / evict_line_i)
//   write_from_victim_i   hit line moves to dcache; invalidate hit entry
//   flush_i               invalidate all entries, reset round-robin pointer
//   count_o, full_o       number of valid entries, all entries valid
//   hit_cnt_o             hit performance counter
//   lookup_cnt_o          lookup performance counter
//
// Optional feature macro: VC_PERF_CNT_EN enables the saturating 32-bit
// performance counters; when undefined both counter outputs are tied to 0.
module victim_cache #(
  parameter int unsigned VC_ENTRIES  = 4,
  parameter int unsigned LINE_ADDR_W = 26,
  parameter int unsigned LINE_W      = 128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              lookup_req_i,
  input  logic [LINE_ADDR_W-1:0]            lookup_addr_i,
  output logic                              victim_hit_o,
  output logic [LINE_W-1:0]                 hit_line_o,
  input  logic                              write_to_victim_i,
  input  logic [LINE_ADDR_W-1:0]            evict_addr_i,
  input  logic [LINE_W-1:0]                 evict_line_i,
  input  logic                              write_from_victim_i,
  input  logic                              flush_i,
  output logic [$clog2(VC_ENTRIES):0]       count_o,
  output logic                              full_o,
  output logic [31:0]                       hit_cnt_o,
  output logic [31:0]                       lookup_cnt_o
);

  localparam int unsigned IDX_W = $clog2(VC_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [VC_ENTRIES-1:0]  valid_q, valid_d, valid_ext;
  logic [LINE_ADDR_W-1:0] tag_q  [VC_ENTRIES];
  logic [LINE_W-1:0]      data_q [VC_ENTRIES];
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   full_q, full_d;

  logic [VC_ENTRIES-1:0]  lk_match, ev_match;
  logic                   hit_c;
  logic [LINE_W-1:0]      hit_line_c;
  logic                   extract;
  logic [IDX_W-1:0]       ins_slot;
  logic                   use_rr;
  logic                   ins_we;

  // Tag compare for lookup and for the evicted address.
  always_comb begin
    lk_match   = '0;
    ev_match   = '0;
    hit_line_c = '0;
    for (int i = 0; i < VC_ENTRIES; i++) begin
      lk_match[i] = valid_q[i] && (tag_q[i] == lookup_addr_i);
      ev_match[i] = valid_q[i] && (tag_q[i] == evict_addr_i);
      // Tags are unique among valid entries, so OR-ing is a clean mux.
      if (lookup_req_i && lk_match[i]) hit_line_c = hit_line_c | data_q[i];
    end
    hit_c = lookup_req_i && (|lk_match);
  end

  assign victim_hit_o = hit_c;
  assign hit_line_o   = hit_line_c;

  // Next valid / round-robin / occupancy state.
  always_comb begin
    logic found;
    extract   = write_from_victim_i && hit_c;
    // An entry being extracted this cycle is free for the insert below.
    valid_ext = valid_q & ~(extract ? lk_match : {VC_ENTRIES{1'b0}});
    ins_slot  = rr_q;
    use_rr    = 1'b0;
    found     = 1'b0;
    if (|ev_match) begin
      for (int i = 0; i < VC_ENTRIES; i++) begin
        if (ev_match[i]) ins_slot = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < VC_ENTRIES; i++) begin
        if (!found && !valid_ext[i]) begin
          ins_slot = IDX_W'(i);
          found    = 1'b1;
        end
      end
      use_rr = !found;
    end

    valid_d = valid_ext;
    rr_d    = rr_q;
    if (write_to_victim_i) begin
      valid_d[ins_slot] = 1'b1;
      if (use_rr) rr_d = IDX_W'(rr_q + IDX_W'(1));
    end
    if (flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end

    count_d = '0;
    for (int i = 0; i < VC_ENTRIES; i++) begin
      count_d = CNT_W'(count_d + CNT_W'(valid_d[i]));
    end
    full_d = (count_d == CNT_W'(VC_ENTRIES));
  end

  assign ins_we = write_to_victim_i && !flush_i && rst_n;

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Tag/data arrays are not reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (ins_we) begin
      tag_q[ins_slot]  <= evict_addr_i;
      data_q[ins_slot] <= evict_line_i;
    end
  end

  assign count_o = count_q;
  assign full_o  = full_q;

`ifdef VC_PERF_CNT_EN
  logic [31:0] hit_cnt_q, lookup_cnt_q;

  // Saturating performance counters; not cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q    <= '0;
      lookup_cnt_q <= '0;
    end else begin
      if (lookup_req_i && (lookup_cnt_q != 32'hFFFF_FFFF)) lookup_cnt_q <= lookup_cnt_q + 32'd1;
      if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF))           hit_cnt_q    <= hit_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o    = hit_cnt_q;
  assign lookup_cnt_o = lookup_cnt_q;
`else
  assign hit_cnt_o    = '0;
  assign lookup_cnt_o = '0;
`endif

endmodule

// File: tb/tb_victim_cache.sv
// Directed self-checking bench for victim_cache (VC_ENTRIES=4).
module tb_victim_cache;

  localparam int unsigned AW = 26;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          victim_hit;
  logic [LW-1:0] hit_line;
  logic          write_to_victim;
  logic [AW-1:0] evict_addr;
  logic [LW-1:0] evict_line;
  logic          write_from_victim;
  logic          flush;
  logic [2:0]    count;
  logic          full;
  logic [31:0]   hit_cnt;
  logic [31:0]   lookup_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          hit;
    logic [LW-1:0] line;
  } exp_t;
  exp_t sb[$];

  victim_cache #(.VC_ENTRIES(4), .LINE_ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lookup_req_i        (lookup_req),
    .lookup_addr_i       (lookup_addr),
    .victim_hit_o        (victim_hit),
    .hit_line_o          (hit_line),
    .write_to_victim_i   (write_to_victim),
    .evict_addr_i        (evict_addr),
    .evict_line_i        (evict_line),
    .write_from_victim_i (write_from_victim),
    .flush_i             (flush),
    .count_o             (count),
    .full_o              (full),
    .hit_cnt_o           (hit_cnt),
    .lookup_cnt_o        (lookup_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] mk(input logic [31:0] s);
    return {s, s ^ 32'h1, s ^ 32'h2, s ^ 32'h3};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    lookup_req        = 1'b0;
    lookup_addr       = '0;
    write_to_victim   = 1'b0;
    evict_addr        = '0;
    evict_line        = '0;
    write_from_victim = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic do_insert(input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clk);
    write_to_victim = 1'b1;
    evict_addr      = a;
    evict_line      = d;
    @(posedge clk);
    #1 clr();
  endtask

  task automatic do_lookup(input string tag, input logic [AW-1:0] a,
                           input logic eh, input logic [LW-1:0] el);
    exp_t e;
    @(negedge clk);
    lookup_req  = 1'b1;
    lookup_addr = a;
    sb.push_back('{hit: eh, line: (eh ? el : '0)});
    #1;
    e = sb.pop_front();
    chk({tag, "_hit"}, LW'(victim_hit), LW'(e.hit));
    chk({tag, "_line"}, hit_line, e.line);
    @(posedge clk);
    #1 clr();
  endtask

  // Extract via lookup+write_from_victim, optionally inserting in the same cycle.
  task automatic do_extract(input string tag, input logic [AW-1:0] la, input logic eh,
                            input logic ins, input logic [AW-1:0] ia, input logic [LW-1:0] id);
    exp_t e;
    @(negedge clk);
    lookup_req        = 1'b1;
    lookup_addr       = la;
    write_from_victim = 1'b1;
    write_to_victim   = ins;
    evict_addr        = ia;
    evict_line        = id;
    sb.push_back('{hit: eh, line: '0});
    #1;
    e = sb.pop_front();
    chk({tag, "_hit"}, LW'(victim_hit), LW'(e.hit));
    @(posedge clk);
    #1 clr();
  endtask

  task automatic do_flush(input logic ins, input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clk);
    flush           = 1'b1;
    write_to_victim = ins;
    evict_addr      = a;
    evict_line      = d;
    @(posedge clk);
    #1 clr();
  endtask

  task automatic chk_state(input string tag, input int ec, input logic ef);
    @(negedge clk);
    chk({tag, "_count"}, LW'(count), LW'(ec));
    chk({tag, "_full"}, LW'(full), LW'(ef));
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", LW'(count), '0);
    chk("rst_full", LW'(full), '0);
    chk("rst_hit", LW'(victim_hit), '0);
    chk("rst_line", hit_line, '0);
    chk("rst_hcnt", LW'(hit_cnt), '0);
    chk("rst_lcnt", LW'(lookup_cnt), '0);
    rst_n = 1'b1;

    // Basic insert then hit next cycle.
    do_lookup("empty_miss", 26'h10, 1'b0, '0);
    do_insert(26'h10, mk(32'hD0D0_0000));
    do_lookup("a10", 26'h10, 1'b1, mk(32'hD0D0_0000));
    chk_state("a10", 1, 1'b0);

    // Fill, then round-robin replacement of entry 0 and entry 1.
    do_flush(1'b0, '0, '0);
    chk_state("flush0", 0, 1'b0);
    for (int k = 1; k <= 4; k++) do_insert(AW'(k), mk(32'h1000_0000 + 32'(k)));
    chk_state("fill4", 4, 1'b1);
    do_insert(26'h5, mk(32'h1000_0005));
    do_lookup("rr_old1", 26'h1, 1'b0, '0);
    do_lookup("rr_new5", 26'h5, 1'b1, mk(32'h1000_0005));
    do_lookup("rr_keep2", 26'h2, 1'b1, mk(32'h1000_0002));
    chk_state("rr5", 4, 1'b1);
    do_insert(26'h6, mk(32'h1000_0006));
    do_lookup("rr_old2", 26'h2, 1'b0, '0);
    do_lookup("rr_new6", 26'h6, 1'b1, mk(32'h1000_0006));

    // Full with address match: overwrite in place, rr stays at 2.
    do_insert(26'h3, mk(32'h3333_0000));
    do_lookup("ovw3", 26'h3, 1'b1, mk(32'h3333_0000));
    do_lookup("ovw_keep4", 26'h4, 1'b1, mk(32'h1000_0004));
    chk_state("ovw", 4, 1'b1);

    // Extract 0x3 and insert 0x9 in the same cycle: 0x9 takes slot 2.
    do_extract("xi3", 26'h3, 1'b1, 1'b1, 26'h9, mk(32'h9999_0000));
    do_lookup("xi_miss3", 26'h3, 1'b0, '0);
    do_lookup("xi_hit9", 26'h9, 1'b1, mk(32'h9999_0000));
    chk_state("xi", 4, 1'b1);
    // rr still 2: next replacement evicts 0x9 (slot 2).
    do_insert(26'hA, mk(32'hAAAA_0000));
    do_lookup("rr2_old9", 26'h9, 1'b0, '0);
    do_lookup("rr2_newA", 26'hA, 1'b1, mk(32'hAAAA_0000));
    do_lookup("rr2_keep4", 26'h4, 1'b1, mk(32'h1000_0004));
    do_lookup("rr2_keep5", 26'h5, 1'b1, mk(32'h1000_0005));

    // Plain extract, and extract request without a hit.
    do_extract("x4", 26'h4, 1'b1, 1'b0, '0, '0);
    chk_state("x4", 3, 1'b0);
    do_lookup("x4_miss", 26'h4, 1'b0, '0);
    do_extract("xmiss", 26'h44, 1'b0, 1'b0, '0, '0);
    chk_state("xmiss", 3, 1'b0);
    do_insert(26'hB, mk(32'hBBBB_0000));
    chk_state("fillB", 4, 1'b1);
    do_lookup("fillB", 26'hB, 1'b1, mk(32'hBBBB_0000));

    // Flush wins over a simultaneous insert; rr returns to 0.
    do_flush(1'b1, 26'h23, mk(32'h2323_0000));
    chk_state("flush", 0, 1'b0);
    do_lookup("fl_5", 26'h5, 1'b0, '0);
    do_lookup("fl_A", 26'hA, 1'b0, '0);
    do_lookup("fl_23", 26'h23, 1'b0, '0);
    for (int k = 0; k < 4; k++) do_insert(AW'(26'h30 + k), mk(32'h3000_0000 + 32'(k)));
    do_insert(26'h34, mk(32'h3000_0004));
    do_lookup("fl_rr0_30", 26'h30, 1'b0, '0);
    do_lookup("fl_rr0_31", 26'h31, 1'b1, mk(32'h3000_0001));

    // Same address inserted twice keeps one entry with the newest data.
    do_flush(1'b0, '0, '0);
    do_insert(26'h7, mk(32'hD1D1_0000));
    do_insert(26'h7, mk(32'hD2D2_0000));
    chk_state("dup7", 1, 1'b0);
    do_lookup("dup7", 26'h7, 1'b1, mk(32'hD2D2_0000));

    // Reset mid-operation drops the pending insert and clears counters.
    @(negedge clk);
    rst_n           = 1'b0;
    write_to_victim = 1'b1;
    evict_addr      = 26'h40;
    evict_line      = mk(32'h4040_0000);
    @(posedge clk);
    #1 clr();
    rst_n = 1'b1;
    chk_state("mrst", 0, 1'b0);

    // Performance counters: 10 lookups, 4 hits.
    do_insert(26'h50, mk(32'h5050_0000));
    do_insert(26'h51, mk(32'h5151_0000));
    do_lookup("pc0", 26'h40, 1'b0, '0);
    do_lookup("pc1", 26'h50, 1'b1, mk(32'h5050_0000));
    do_lookup("pc2", 26'h51, 1'b1, mk(32'h5151_0000));
    do_lookup("pc3", 26'h52, 1'b0, '0);
    do_lookup("pc4", 26'h50, 1'b1, mk(32'h5050_0000));
    do_lookup("pc5", 26'h53, 1'b0, '0);
    do_lookup("pc6", 26'h51, 1'b1, mk(32'h5151_0000));
    do_lookup("pc7", 26'h54, 1'b0, '0);
    do_lookup("pc8", 26'h55, 1'b0, '0);
    do_lookup("pc9", 26'h56, 1'b0, '0);
    @(negedge clk);
`ifdef VC_PERF_CNT_EN
    chk("lookup_cnt", LW'(lookup_cnt), LW'(32'd10));
    chk("hit_cnt", LW'(hit_cnt), LW'(32'd4));
`else
    chk("lookup_cnt", LW'(lookup_cnt), '0);
    chk("hit_cnt", LW'(hit_cnt), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
